puf_challenge_driver: RTL

- Initiator side of the dual-adder arbiter PUF.
- Accepts a challenge (operands plus two PDL configuration words) over a valid/ready request channel.
- Drives the PUF's operand and config inputs through precharge/launch cycles and samples the 32-bit arbiter response.
- Repeats the evaluation NUM_EVAL times and returns a per-bit majority-voted response on a valid/ready response channel.
- Sits between the host/ethernet command logic and the PUF core.

---
 rtl/puf_challenge_driver_pkg.sv | 23 ++
 rtl/puf_challenge_driver_if.sv | 46 ++++
 rtl/puf_bit_voter.sv | 52 +++++
 rtl/puf_challenge_driver.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/puf_challenge_driver_pkg.sv
// Shared types and defaults for the arbiter-PUF challenge driver.
// Optional build macro used by this block: PUF_DRV_UNSTABLE_MASK_EN.
package puf_pkg;

  localparam int unsigned DEF_WIDTH         = 32;
  localparam int unsigned DEF_CFG_W         = 128;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_NUM_EVAL      = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    RUN    = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 32'd1) ? 32'd1 : $clog2(n + 32'd1);
  endfunction

endpackage

// File: rtl/puf_challenge_driver_if.sv
// Request, PUF-drive and response channels of the challenge driver.
// The slave modport is the driver itself; master is the host/PUF side.
interface puf_challenge_driver_if
  import puf_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CFG_W = DEF_CFG_W
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [CFG_W-1:0] req_cfg1;
  logic [CFG_W-1:0] req_cfg2;

  logic [WIDTH-1:0] puf_a;
  logic [WIDTH-1:0] puf_b;
  logic [CFG_W-1:0] puf_cfg1;
  logic [CFG_W-1:0] puf_cfg2;
  logic [WIDTH-1:0] puf_c;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [WIDTH-1:0] rsp_unstable;

  modport slave (
    input  req_valid, req_a, req_b, req_cfg1, req_cfg2,
    output req_ready,
    output puf_a, puf_b, puf_cfg1, puf_cfg2,
    input  puf_c,
    output rsp_valid, rsp_data, rsp_unstable,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_cfg1, req_cfg2,
    input  req_ready,
    input  puf_a, puf_b, puf_cfg1, puf_cfg2,
    output puf_c,
    input  rsp_valid, rsp_data, rsp_unstable,
    output rsp_ready
  );

endinterface

// File: rtl/puf_bit_voter.sv
// One response bit: counts ones over the evaluations of a challenge and
// reports the majority (and, with PUF_DRV_UNSTABLE_MASK_EN, disagreement).
module puf_bit_voter
  import puf_pkg::*;
#(
  parameter int unsigned NUM_EVAL = DEF_NUM_EVAL,
  parameter int unsigned CW       = cnt_w(NUM_EVAL)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  input  logic bit_i,
  output logic maj_o
`ifdef PUF_DRV_UNSTABLE_MASK_EN
  , output logic unstable_o
`endif
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on a new challenge, add the sampled bit in SAMPLE.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && bit_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Ones-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Votes look at the next count so the final sample is included when
  // the driver registers the response on its way into DONE.
  assign maj_o = (cnt_d > CW'(NUM_EVAL / 32'd2));

`ifdef PUF_DRV_UNSTABLE_MASK_EN
  assign unstable_o = (cnt_d != '0) && (cnt_d != CW'(NUM_EVAL));
`endif

endmodule

// File: rtl/puf_challenge_driver.sv
// Initiator for the dual-adder arbiter PUF: precharge/launch/sample cycles,
// NUM_EVAL repeats, per-bit majority vote. Optional: PUF_DRV_UNSTABLE_MASK_EN.
module puf_challenge_driver
  import puf_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned CFG_W         = DEF_CFG_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned NUM_EVAL      = DEF_NUM_EVAL
) (
  input logic                  clk,
  input logic                  rst_n,
  puf_challenge_driver_if.slave bus
);

  localparam int unsigned EW = cnt_w(NUM_EVAL);
  localparam int unsigned PW = cnt_w(SETTLE_CYCLES);

  state_e           state_q;
  logic [PW-1:0]    phase_q;
  logic [EW-1:0]    eval_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] puf_a_q;
  logic [WIDTH-1:0] puf_b_q;
  logic [CFG_W-1:0] cfg1_q;
  logic [CFG_W-1:0] cfg2_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             clr_s;
  logic             inc_s;
  logic             phase_end_s;
  logic             last_eval_s;
  logic [WIDTH-1:0] maj_s;

  assign clr_s       = (state_q == IDLE) && bus.req_valid && req_ready_q;
  assign inc_s       = (state_q == SAMPLE);
  assign phase_end_s = (phase_q == PW'(SETTLE_CYCLES - 32'd1));
  assign last_eval_s = (eval_q == EW'(NUM_EVAL - 32'd1));

`ifdef PUF_DRV_UNSTABLE_MASK_EN
  logic [WIDTH-1:0] unst_s;
  logic [WIDTH-1:0] rsp_unstable_q;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    puf_bit_voter #(
      .NUM_EVAL (NUM_EVAL)
    ) u_voter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr_s),
      .inc_i      (inc_s),
      .bit_i      (bus.puf_c[gi]),
      .maj_o      (maj_s[gi])
`ifdef PUF_DRV_UNSTABLE_MASK_EN
      , .unstable_o (unst_s[gi])
`endif
    );
  end

  // Challenge FSM; every output is a register updated on the transition
  // into the state that owns its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      eval_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      puf_a_q     <= '0;
      puf_b_q     <= '0;
      cfg1_q      <= '0;
      cfg2_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef PUF_DRV_UNSTABLE_MASK_EN
      rsp_unstable_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            a_q         <= bus.req_a;
            b_q         <= bus.req_b;
            cfg1_q      <= bus.req_cfg1;
            cfg2_q      <= bus.req_cfg2;
            puf_a_q     <= '0;
            puf_b_q     <= '0;
            eval_q      <= '0;
            phase_q     <= '0;
            req_ready_q <= 1'b0;
            state_q     <= PRE;
          end
        end
        PRE: begin
          if (phase_end_s) begin
            phase_q <= '0;
            puf_a_q <= a_q;
            puf_b_q <= b_q;
            state_q <= RUN;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        RUN: begin
          if (phase_end_s) begin
            phase_q <= '0;
            state_q <= SAMPLE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        SAMPLE: begin
          eval_q  <= eval_q + EW'(1);
          puf_a_q <= '0;
          puf_b_q <= '0;
          if (last_eval_s) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= maj_s;
`ifdef PUF_DRV_UNSTABLE_MASK_EN
            rsp_unstable_q <= unst_s;
`endif
            state_q     <= DONE;
          end else begin
            state_q <= PRE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          phase_q     <= '0;
          eval_q      <= '0;
          puf_a_q     <= '0;
          puf_b_q     <= '0;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.puf_a     = puf_a_q;
  assign bus.puf_b     = puf_b_q;
  assign bus.puf_cfg1  = cfg1_q;
  assign bus.puf_cfg2  = cfg2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef PUF_DRV_UNSTABLE_MASK_EN
  assign bus.rsp_unstable = rsp_unstable_q;
`else
  assign bus.rsp_unstable = '0;
`endif

endmodule
